// File: rtl/unidade_controle_if.sv
// Control bus between the instruction source and the multicycle controller:
// instruction handshake in, ALU control, datapath strobes and status out.
interface unidade_controle_if;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned ALU_W   = 4;
   localparam int unsigned IMM_W   = 12;

   logic               instr_valid;
   logic [INSTR_W-1:0] instrucao;
   logic [STATE_W-1:0] estado;
   logic [ALU_W-1:0]   alucontrol;
   logic               alusrc;
   logic [IMM_W-1:0]   imediato;
   logic               negativo;
   logic               branch;
   logic               reg_write;
   logic               mem_read;
   logic               mem_write;
   logic               mem_to_reg;
   logic               pc_write;
   logic               busy;
   logic               done;
   logic               ilegal;

   modport master (
      output instr_valid, instrucao,
      input  estado, alucontrol, alusrc, imediato, negativo, branch,
             reg_write, mem_read, mem_write, mem_to_reg, pc_write,
             busy, done, ilegal
   );

   modport slave (
      input  instr_valid, instrucao,
      output estado, alucontrol, alusrc, imediato, negativo, branch,
             reg_write, mem_read, mem_write, mem_to_reg, pc_write,
             busy, done, ilegal
   );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle RV32I-subset control FSM: decodes one instruction at a time and
// sequences ALU controls, register-file, memory and PC strobes.
module unidade_controle (
   input  logic              clk,
   input  logic              rst_n,
   unidade_controle_if.slave bus
);
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ALU_W   = 4;
   localparam int unsigned IMM_W   = 12;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0000,
      ST_DECODE  = 4'b0010,
      ST_READ    = 4'b0011,
      ST_EXEC_RI = 4'b0101,
      ST_EXEC_MB = 4'b0110,
      ST_MEM     = 4'b0111,
      ST_WB      = 4'b1000,
      ST_PC      = 4'b1001,
      ST_TRAP    = 4'b1111
   } state_t;

   typedef enum logic [2:0] {
      K_R, K_OPI, K_LOAD, K_STORE, K_BRANCH, K_ILLEGAL
   } kind_t;

   typedef struct packed {
      kind_t            kind;
      logic [ALU_W-1:0] alucontrol;
      logic             alusrc;
      logic             branch;
      logic [IMM_W-1:0] imm;
   } decode_t;

   state_t             state, state_nx;
   logic [INSTR_W-1:0] instr_q;
   decode_t            dec;
   logic               imm_neg;
   logic [IMM_W-1:0]   imm_mag;

   logic [ALU_W-1:0]   alucontrol_q;
   logic               alusrc_q, branch_q, negativo_q;
   logic [IMM_W-1:0]   imediato_q;
   logic               busy_q, done_q, ilegal_q, pc_write_q;
   logic               reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
   logic               busy_d, done_d, ilegal_d, pc_write_d;
   logic               reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d;

   // rs1 is consumed by the datapath only
   logic unused_rs1;
   assign unused_rs1 = ^instr_q[19:15];

   // Instruction decode from the latched word
   always_comb begin
      dec.kind       = K_ILLEGAL;
      dec.alucontrol = '0;
      dec.alusrc     = 1'b0;
      dec.branch     = 1'b0;
      dec.imm        = '0;
      case (instr_q[6:0])
         OP_R: begin
            dec.kind = K_R;
            case (instr_q[14:12])
               3'b000: begin
                  if (instr_q[31:25] == 7'b0000000)      dec.alucontrol = 4'b0010;
                  else if (instr_q[31:25] == 7'b0100000) dec.alucontrol = 4'b0110;
                  else                                   dec.kind = K_ILLEGAL;
               end
               3'b111: dec.alucontrol = 4'b0000;
               3'b110: dec.alucontrol = 4'b0001;
               3'b100: dec.alucontrol = 4'b0100;
               3'b101: begin
                  if (instr_q[31:25] == 7'b0000000) dec.alucontrol = 4'b0101;
                  else                              dec.kind = K_ILLEGAL;
               end
               3'b001: dec.alucontrol = 4'b1010;
               default: dec.kind = K_ILLEGAL;
            endcase
         end
         OP_IMM: begin
            dec.kind   = K_OPI;
            dec.alusrc = 1'b1;
            dec.imm    = instr_q[31:20];
            case (instr_q[14:12])
               3'b000: dec.alucontrol = 4'b0011;
               3'b110: dec.alucontrol = 4'b1001;
               3'b001: begin
                  dec.alucontrol = 4'b1010;
                  dec.imm        = {7'b0000000, instr_q[24:20]};
               end
               default: dec.kind = K_ILLEGAL;
            endcase
         end
         OP_LOAD: begin
            dec.kind   = K_LOAD;
            dec.alusrc = 1'b1;
            dec.imm    = instr_q[31:20];
            case (instr_q[14:12])
               3'b010:  dec.alucontrol = 4'b0010;
               3'b000:  dec.alucontrol = 4'b1100;
               default: dec.kind = K_ILLEGAL;
            endcase
         end
         OP_STORE: begin
            dec.kind   = K_STORE;
            dec.alusrc = 1'b1;
            dec.imm    = {instr_q[31:25], instr_q[11:7]};
            if (instr_q[14:12] == 3'b010) dec.alucontrol = 4'b0010;
            else                          dec.kind = K_ILLEGAL;
         end
         OP_BRANCH: begin
            dec.kind   = K_BRANCH;
            dec.alusrc = 1'b1;
            dec.branch = 1'b1;
            // B-format offset is kept halved, so it fits the 12-bit field
            dec.imm    = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
            case (instr_q[14:12])
               3'b000:  dec.alucontrol = 4'b0110;
               3'b001:  dec.alucontrol = 4'b1111;
               default: dec.kind = K_ILLEGAL;
            endcase
         end
         default: dec.kind = K_ILLEGAL;
      endcase
      if (dec.kind == K_ILLEGAL) begin
         dec.alucontrol = '0;
         dec.alusrc     = 1'b0;
         dec.branch     = 1'b0;
         dec.imm        = '0;
      end
   end

   // Sign/magnitude split; -2048 maps to magnitude 0x800
   assign imm_neg = dec.imm[IMM_W-1];
   assign imm_mag = imm_neg ? ((~dec.imm) + 12'd1) : dec.imm;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ilegal_q     <= 1'b0;
         pc_write_q   <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else begin
         state        <= state_nx;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ilegal_q     <= ilegal_d;
         pc_write_q   <= pc_write_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
      end
   end

   // Instruction latch on accept; ALU controls captured on leaving DECODE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q      <= '0;
         alucontrol_q <= '0;
         alusrc_q     <= 1'b0;
         branch_q     <= 1'b0;
         imediato_q   <= '0;
         negativo_q   <= 1'b0;
      end else begin
         if (state == ST_IDLE && bus.instr_valid) instr_q <= bus.instrucao;
         if (state == ST_DECODE) begin
            alucontrol_q <= dec.alucontrol;
            alusrc_q     <= dec.alusrc;
            branch_q     <= dec.branch;
            imediato_q   <= imm_mag;
            negativo_q   <= imm_neg;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (bus.instr_valid) state_nx = ST_DECODE;
         ST_DECODE:  state_nx = (dec.kind == K_ILLEGAL) ? ST_TRAP : ST_READ;
         ST_READ:    state_nx = (dec.kind == K_R || dec.kind == K_OPI) ? ST_EXEC_RI : ST_EXEC_MB;
         ST_EXEC_RI: state_nx = ST_WB;
         ST_EXEC_MB: state_nx = (dec.kind == K_BRANCH) ? ST_PC : ST_MEM;
         ST_MEM:     state_nx = (dec.kind == K_LOAD) ? ST_WB : ST_PC;
         ST_WB:      state_nx = ST_PC;
         ST_PC:      state_nx = ST_IDLE;
         ST_TRAP:    state_nx = ST_TRAP;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they register in step with estado
   always_comb begin
      busy_d       = 1'b0;
      done_d       = 1'b0;
      ilegal_d     = 1'b0;
      pc_write_d   = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      busy_d       = (state_nx != ST_IDLE);
      ilegal_d     = (state_nx == ST_TRAP);
      done_d       = (state_nx == ST_PC);
      pc_write_d   = (state_nx == ST_PC);
      reg_write_d  = (state_nx == ST_WB);
      mem_to_reg_d = (state_nx == ST_WB)  && (dec.kind == K_LOAD);
      mem_read_d   = (state_nx == ST_MEM) && (dec.kind == K_LOAD);
      mem_write_d  = (state_nx == ST_MEM) && (dec.kind == K_STORE);
   end

   assign bus.estado     = state;
   assign bus.alucontrol = alucontrol_q;
   assign bus.alusrc     = alusrc_q;
   assign bus.imediato   = imediato_q;
   assign bus.negativo   = negativo_q;
   assign bus.branch     = branch_q;
   assign bus.reg_write  = reg_write_q;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_to_reg = mem_to_reg_q;
   assign bus.pc_write   = pc_write_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.ilegal     = ilegal_q;
endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed instructions with literal expectations,
// then random traffic checked every cycle against a path-list reference model.
module tb_unidade_controle;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   unidade_controle_if bus ();

   unidade_controle dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADD  = 32'h002081B3;
   localparam logic [31:0] ADDI = 32'hFFB00093;
   localparam logic [31:0] LW   = 32'hFF812283;
   localparam logic [31:0] SW   = 32'h80002023;
   localparam logic [31:0] BNE  = 32'h00209863;
   localparam logic [31:0] BAD  = 32'hFFFFFFFF;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [30:0] all_outs();
      return {bus.estado, bus.alucontrol, bus.alusrc, bus.imediato, bus.negativo,
              bus.branch, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
              bus.pc_write, bus.busy, bus.done, bus.ilegal};
   endfunction

   // Reference decode: kind 0=R 1=OP-IMM 2=load 3=store 4=branch 5=illegal
   function automatic int ref_decode(input logic [31:0] w, output logic [3:0] alu,
                                     output logic src, output logic br,
                                     output logic [11:0] mag, output logic neg);
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] raw;
      int iv;
      int k;
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      alu = 4'd0; src = 1'b0; br = 1'b0; iv = 0; k = 5;
      case (op)
         7'h33: begin
            k = 0;
            if (f3 == 3'd0 && f7 == 7'h00)      alu = 4'd2;
            else if (f3 == 3'd0 && f7 == 7'h20) alu = 4'd6;
            else if (f3 == 3'd7)                alu = 4'd0;
            else if (f3 == 3'd6)                alu = 4'd1;
            else if (f3 == 3'd4)                alu = 4'd4;
            else if (f3 == 3'd5 && f7 == 7'h00) alu = 4'd5;
            else if (f3 == 3'd1)                alu = 4'd10;
            else                                k = 5;
         end
         7'h13: begin
            k = 1; src = 1'b1;
            iv = int'($signed(w[31:20]));
            if (f3 == 3'd0)      alu = 4'd3;
            else if (f3 == 3'd6) alu = 4'd9;
            else if (f3 == 3'd1) begin alu = 4'd10; iv = int'(w[24:20]); end
            else                 k = 5;
         end
         7'h03: begin
            k = 2; src = 1'b1;
            iv = int'($signed(w[31:20]));
            if (f3 == 3'd2)      alu = 4'd2;
            else if (f3 == 3'd0) alu = 4'd12;
            else                 k = 5;
         end
         7'h23: begin
            k = 3; src = 1'b1;
            raw = {w[31:25], w[11:7]};
            iv = int'($signed(raw));
            if (f3 == 3'd2) alu = 4'd2;
            else            k = 5;
         end
         7'h63: begin
            k = 4; src = 1'b1; br = 1'b1;
            raw = {w[31], w[7], w[30:25], w[11:8]};
            iv = int'($signed(raw));
            if (f3 == 3'd0)      alu = 4'd6;
            else if (f3 == 3'd1) alu = 4'd15;
            else                 k = 5;
         end
         default: k = 5;
      endcase
      if (k == 5) begin alu = 4'd0; src = 1'b0; br = 1'b0; iv = 0; end
      neg = (iv < 0);
      mag = 12'(neg ? -iv : iv);
      return k;
   endfunction

   // Reference model: current state code plus the list of codes still to visit
   logic [3:0]  m_state;
   int          m_path[$];
   bit          m_load, m_store;
   logic [3:0]  p_alu, e_alu;
   logic        p_src, e_src, p_br, e_br, p_neg, e_neg;
   logic [11:0] p_mag, e_mag;

   task automatic model_reset();
      m_state = 4'h0; m_path.delete(); m_load = 0; m_store = 0;
      e_alu = 4'h0; e_src = 0; e_br = 0; e_neg = 0; e_mag = 12'h0;
   endtask

   task automatic model_step();
      int k;
      if (m_state == 4'h0) begin
         if (bus.instr_valid) begin
            k = ref_decode(bus.instrucao, p_alu, p_src, p_br, p_mag, p_neg);
            m_load = (k == 2); m_store = (k == 3);
            case (k)
               0, 1:    m_path = '{3, 5, 8, 9};
               2:       m_path = '{3, 6, 7, 8, 9};
               3:       m_path = '{3, 6, 7, 9};
               4:       m_path = '{3, 6, 9};
               default: m_path = '{15};
            endcase
            m_state = 4'h2;
         end
      end else if (m_state != 4'hF) begin
         if (m_state == 4'h2) begin
            e_alu = p_alu; e_src = p_src; e_br = p_br; e_mag = p_mag; e_neg = p_neg;
         end
         if (m_path.size() > 0) m_state = 4'(m_path.pop_front());
         else                   m_state = 4'h0;
      end
   endtask

   // Per-cycle compare against the model
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else begin
         model_step();
         #1;
         chk("ctrl",
             32'({bus.estado, bus.busy, bus.done, bus.pc_write, bus.reg_write,
                  bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.ilegal}),
             32'({m_state, m_state != 4'h0, m_state == 4'h9, m_state == 4'h9,
                  m_state == 4'h8, m_state == 4'h7 && m_load, m_state == 4'h7 && m_store,
                  m_state == 4'h8 && m_load, m_state == 4'hF}));
         if (m_state != 4'hF)
            chk("fields",
                32'({bus.alucontrol, bus.alusrc, bus.branch, bus.imediato, bus.negativo}),
                32'({e_alu, e_src, e_br, e_mag, e_neg}));
      end
   end

   // Issue one instruction and pin its state path, fields and retirement strobes
   task automatic issue(input string nm, input logic [31:0] w, input logic [31:0] path,
                        input logic [3:0] alu, input logic [11:0] imm, input logic neg);
      logic [31:0] seen;
      int cyc;
      bit fin;
      @(negedge clk);
      if (bus.estado != 4'h0) @(negedge clk);
      bus.instr_valid = 1'b1; bus.instrucao = w;
      seen = 32'h0; fin = 0; cyc = 0;
      while (!fin && cyc < 12) begin
         @(posedge clk); #1;
         bus.instr_valid = 1'b0;
         cyc++;
         seen = {seen[27:0], bus.estado};
         if (cyc == 2)
            chk({nm, "_fields"}, 32'({bus.alucontrol, bus.imediato, bus.negativo}),
                32'({alu, imm, neg}));
         if (bus.done) begin
            fin = 1;
            chk({nm, "_strobes"}, 32'({bus.pc_write, bus.reg_write, bus.mem_read, bus.mem_write}),
                32'(4'b1000));
         end
      end
      chk({nm, "_path"}, seen, path);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      int sel;
      w = $urandom();
      sel = $urandom_range(0, 5);
      case (sel)
         0: w[6:0] = 7'b0110011;
         1: w[6:0] = 7'b0010011;
         2: w[6:0] = 7'b0000011;
         3: w[6:0] = 7'b0100011;
         4: w[6:0] = 7'b1100011;
         default: ;
      endcase
      if ($urandom_range(0, 4) != 0) begin
         case (sel)
            0: begin
               case ($urandom_range(0, 5))
                  0: w[14:12] = 3'd0; 1: w[14:12] = 3'd7; 2: w[14:12] = 3'd6;
                  3: w[14:12] = 3'd4; 4: w[14:12] = 3'd5; default: w[14:12] = 3'd1;
               endcase
               w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            end
            1: w[14:12] = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd6;
            2: w[14:12] = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd0;
            3: w[14:12] = 3'd2;
            4: w[14:12] = 3'(32'($urandom_range(0, 1)));
            default: ;
         endcase
      end
      if ($urandom_range(0, 7) == 0) begin
         w[31] = 1'b1; w[30:20] = 11'h0; w[11:7] = 5'h0;
      end
      return w;
   endfunction

   initial begin
      bus.instr_valid = 1'b0;
      bus.instrucao   = 32'h0;
      repeat (2) @(posedge clk);
      #1 chk("reset_outs", 32'(all_outs()), 32'h0);
      @(negedge clk) rst_n = 1'b1;

      issue("add",  ADD,  32'h00023589,  4'h2, 12'h000, 1'b0);
      issue("addi", ADDI, 32'h00023589,  4'h3, 12'h005, 1'b1);
      issue("lw",   LW,   32'h00236789,  4'h2, 12'h008, 1'b1);
      issue("sw",   SW,   32'h00023679,  4'h2, 12'h800, 1'b1);
      issue("bne",  BNE,  32'h00002369,  4'hF, 12'h008, 1'b0);
      chk("bne_branch", 32'(bus.branch), 32'h1);

      // Asynchronous reset in the middle of EXEC_RI
      @(negedge clk); @(negedge clk);
      bus.instr_valid = 1'b1; bus.instrucao = ADD;
      @(posedge clk); #1 bus.instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("pre_rst_state", 32'(bus.estado), 32'h5);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_outs", 32'(all_outs()), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      issue("after_rst", ADDI, 32'h00023589, 4'h3, 12'h005, 1'b1);

      // Illegal word traps and stays there
      @(negedge clk); @(negedge clk);
      bus.instr_valid = 1'b1; bus.instrucao = BAD;
      @(posedge clk); #1 bus.instr_valid = 1'b0;
      chk("bad_decode", 32'(bus.estado), 32'h2);
      @(posedge clk); #1;
      chk("bad_trap", 32'({bus.estado, bus.ilegal, bus.busy}), 32'({4'hF, 1'b1, 1'b1}));
      repeat (5) begin
         @(negedge clk); bus.instr_valid = 1'b1; bus.instrucao = ADD;
         @(posedge clk); #1;
         chk("trap_sticky", 32'({bus.estado, bus.ilegal, bus.busy, bus.done}),
             32'({4'hF, 1'b1, 1'b1, 1'b0}));
      end
      @(negedge clk) begin bus.instr_valid = 1'b0; rst_n = 1'b0; end
      @(negedge clk) rst_n = 1'b1;

      // Random traffic with occasional asynchronous resets
      repeat (3000) begin
         @(negedge clk);
         bus.instr_valid = ($urandom_range(0, 3) != 0);
         bus.instrucao   = gen_instr();
         if ((m_state == 4'hF && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0) begin
            @(posedge clk); #3 rst_n = 1'b0;
            #1 chk("rand_rst_outs", 32'(all_outs()), 32'h0);
            @(negedge clk) rst_n = 1'b1;
         end
      end
      @(negedge clk) bus.instr_valid = 1'b0;
      repeat (8) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
